// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS control logic.
//   state_t  - multicycle controller states (4-bit encoding)
//   OP_*     - instr[31:26] opcodes recognised by the controllers
//   FN_*     - instr[5:0] R-type function codes
//   ALU_*    - ALU function encodings driven on alucontrol
//   aluop_t  - coarse ALU request from a controller to alu_decoder
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef logic [2:0] aluctl_t;

    localparam aluctl_t ALU_ADD = 3'b010;
    localparam aluctl_t ALU_SUB = 3'b110;
    localparam aluctl_t ALU_AND = 3'b000;
    localparam aluctl_t ALU_OR  = 3'b001;
    localparam aluctl_t ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps a controller's ALU request and the R-type funct field to
// the ALU function code. Purely combinational; shared with the single-cycle core.
//   aluop      in   ALU request: add, sub, or decode from funct
//   funct      in   instr[5:0]
//   alucontrol out  ALU function encoding (add when nothing else applies)
//   bad_funct  out  high when aluop asks for funct decode and funct is unsupported
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output aluctl_t    alucontrol,
    output logic       bad_funct
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise a latch is inferred.
    always_comb begin
        alucontrol = ALU_ADD;
        bad_funct  = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: bad_funct  = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for the multicycle MIPS datapath.
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   op, funct, zero      instruction fields and ALU zero flag
//   pcen                 PC enable = pcwrite | (branch & zero)
//   irwrite, memwrite,
//   regwrite             write strobes (at most one high per cycle)
//   iord, alusrca,
//   alusrcb, pcsrc,
//   memtoreg, regdst     datapath mux selects
//   alucontrol           ALU function
//   illegal              one-cycle pulse on an unsupported op or funct
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    output logic                pcen,
    output logic                irwrite,
    output logic                memwrite,
    output logic                regwrite,
    output logic                iord,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic                memtoreg,
    output logic                regdst,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                illegal
);

    state_t  state, state_next;
    logic    is_sw;        // lw/sw choice captured in DECODE, op is not sampled later
    aluop_t  aluop;
    aluctl_t dec_ctl;
    logic    bad_funct;
    logic    op_legal;
    logic    pcwrite, branch, irwrite_s, memwrite_s, regwrite_s, illegal_s;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            is_sw <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                is_sw <= (op == OP_SW);
        end
    end

    assign aluop = (state == S_RTYPEEX) ? ALUOP_FUNCT :
                   (state == S_BEQEX)   ? ALUOP_SUB   : ALUOP_ADD;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (dec_ctl),
        .bad_funct  (bad_funct)
    );

    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                      (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = S_MEMWB;
            S_RTYPEEX: state_next = bad_funct ? S_FETCH : S_RTYPEWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            // Terminal states and any unencoded value return to FETCH.
            default:   state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        illegal_s  = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        case (state)
            S_FETCH: begin
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
                alusrcb   = 2'b01;
            end
            S_DECODE: begin
                alusrcb   = 2'b11;
                illegal_s = ~op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca   = 1'b1;
                illegal_s = bad_funct;
            end
            S_RTYPEWB: begin
                regwrite_s = 1'b1;
                regdst     = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB: regwrite_s = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign alucontrol = ALUCTL_W'(dec_ctl);

    // Reset gates the enables combinationally so a write stops at the
    // asserting edge of reset, not at the next clock.
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;
    assign irwrite  = irwrite_s  & ~reset;
    assign memwrite = memwrite_s & ~reset;
    assign regwrite = regwrite_s & ~reset;
    assign illegal  = illegal_s  & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven latency/strobe vectors, directed
// corner cases, and random instructions checked against an instruction-level
// reference model of the controller.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       memtoreg;
        logic       regdst;
        logic [2:0] alucontrol;
        logic       illegal;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         latency;
        int         n_pcen;
        int         n_regwrite;
        int         n_memwrite;
        int         n_illegal;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, irwrite, memwrite, regwrite, iord, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       memtoreg, regdst, illegal;
    logic [2:0] alucontrol;
    outs_t      act;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.ALUCTL_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    assign act = {pcen, irwrite, memwrite, regwrite, iord, alusrca, alusrcb,
                  pcsrc, memtoreg, regdst, alucontrol, illegal};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    function automatic bit is_legal_op(input logic [5:0] o);
        return o == OP_LW || o == OP_SW || o == OP_RTYPE || o == OP_BEQ ||
               o == OP_ADDI || o == OP_J;
    endfunction

    function automatic bit funct_code(input logic [5:0] f, output logic [2:0] code);
        code = 3'b010;
        case (f)
            6'b100000: code = 3'b010;
            6'b100010: code = 3'b110;
            6'b100100: code = 3'b000;
            6'b100101: code = 3'b001;
            6'b101010: code = 3'b111;
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // Cycles from one FETCH to the next.
    function automatic int instr_len(input logic [5:0] o, input logic [5:0] f);
        logic [2:0] c;
        if (!is_legal_op(o)) return 2;
        case (o)
            OP_LW:    return 5;
            OP_SW:    return 4;
            OP_RTYPE: return funct_code(f, c) ? 4 : 3;
            OP_ADDI:  return 4;
            default:  return 3;   // beq, j
        endcase
    endfunction

    function automatic outs_t fetch_view();
        outs_t o = '0;
        o.alusrcb    = 2'b01;
        o.alucontrol = 3'b010;
        return o;
    endfunction

    // Expected outputs in cycle k (0 = FETCH) of instruction {o, f}.
    function automatic outs_t exp_cycle(input logic [5:0] o, input logic [5:0] f,
                                        input int k, input logic z);
        outs_t e = '0;
        logic [2:0] c;
        e.alucontrol = 3'b010;
        if (k == 0) begin
            e = fetch_view();
            e.irwrite = 1'b1;
            e.pcen    = 1'b1;
            return e;
        end
        if (k == 1) begin
            e.alusrcb = 2'b11;
            e.illegal = !is_legal_op(o);
            return e;
        end
        case (o)
            OP_LW, OP_SW: begin
                if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                if (k == 3) begin e.iord = 1'b1; e.memwrite = (o == OP_SW); end
                if (k == 4) begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            end
            OP_RTYPE: begin
                if (k == 2) begin
                    e.alusrca = 1'b1;
                    if (funct_code(f, c)) e.alucontrol = c;
                    else                  e.illegal = 1'b1;
                end
                if (k == 3) begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            end
            OP_BEQ: begin
                e.alusrca    = 1'b1;
                e.alucontrol = 3'b110;
                e.pcsrc      = 2'b01;
                e.pcen       = z;
            end
            OP_ADDI: begin
                if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                if (k == 3) e.regwrite = 1'b1;
            end
            OP_J: begin
                e.pcsrc = 2'b10;
                e.pcen  = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Runs one instruction from FETCH, driving the real op/funct only where
    // they are sampled and random values elsewhere; zero is random each cycle.
    task automatic run_model(input string tag, input logic [5:0] o, input logic [5:0] f);
        int n = instr_len(o, f);
        for (int k = 0; k < n; k++) begin
            bool_drive(o, f, k);
            #1;
            check($sformatf("%s cycle %0d", tag, k), 32'(act), 32'(exp_cycle(o, f, k, zero)));
            @(posedge clk); #1;
        end
    endtask

    task automatic bool_drive(input logic [5:0] o, input logic [5:0] f, input int k);
        bit sample_op = (k == 1) || (k == 2 && o == OP_RTYPE);
        op    = sample_op ? o : 6'($urandom);
        funct = (k == 2 && o == OP_RTYPE) ? f : 6'($urandom);
        zero  = 1'($urandom);
    endtask

    // Holds inputs constant, counts cycles and strobes until FETCH returns.
    task automatic run_vec(input vec_t v);
        int c = 0, np = 0, nr = 0, nm = 0, ni = 0;
        bit done = 0;
        op = v.op; funct = v.funct; zero = v.zero;
        while (!done && c < 12) begin
            #1;
            if (c > 0 && irwrite) done = 1;
            else begin
                np += int'(pcen); nr += int'(regwrite);
                nm += int'(memwrite); ni += int'(illegal);
                @(posedge clk); #1;
                c++;
            end
        end
        check({v.name, " latency"},  32'(c),  32'(v.latency));
        check({v.name, " pcen"},     32'(np), 32'(v.n_pcen));
        check({v.name, " regwrite"}, 32'(nr), 32'(v.n_regwrite));
        check({v.name, " memwrite"}, 32'(nm), 32'(v.n_memwrite));
        check({v.name, " illegal"},  32'(ni), 32'(v.n_illegal));
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] o, f;
        outs_t e;
        vecs[0] = '{"lw",       OP_LW,     6'h00,  1'b0, 5, 1, 1, 0, 0};
        vecs[1] = '{"sw",       OP_SW,     6'h00,  1'b0, 4, 1, 0, 1, 0};
        vecs[2] = '{"r_add",    OP_RTYPE,  FN_ADD, 1'b0, 4, 1, 1, 0, 0};
        vecs[3] = '{"r_slt",    OP_RTYPE,  FN_SLT, 1'b1, 4, 1, 1, 0, 0};
        vecs[4] = '{"r_bad",    OP_RTYPE,  6'h07,  1'b1, 3, 1, 0, 0, 1};
        vecs[5] = '{"beq_z1",   OP_BEQ,    6'h00,  1'b1, 3, 2, 0, 0, 0};
        vecs[6] = '{"beq_z0",   OP_BEQ,    6'h00,  1'b0, 3, 1, 0, 0, 0};
        vecs[7] = '{"addi",     OP_ADDI,   6'h00,  1'b1, 4, 1, 1, 0, 0};
        vecs[8] = '{"j",        OP_J,      6'h00,  1'b0, 3, 2, 0, 0, 0};
        vecs[9] = '{"bad_op",   6'h3f,     6'h00,  1'b1, 2, 1, 0, 0, 1};

        // Reset held three cycles: enables low, selects at FETCH values.
        reset = 1'b1; op = OP_SW; funct = FN_ADD; zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("reset hold %0d", i), 32'(act), 32'(fetch_view()));
        end
        reset = 1'b0;
        #1;
        check("fetch after release", 32'(act), 32'(exp_cycle(OP_LW, 6'h0, 0, zero)));

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Directed sequences through the model, including the spec's examples.
        run_model("lw",       OP_LW,    6'h00);
        run_model("r_slt",    OP_RTYPE, FN_SLT);
        run_model("r_bad",    OP_RTYPE, 6'b000111);
        run_model("beq",      OP_BEQ,   6'h00);
        run_model("bad_op",   6'h3f,    6'h00);

        // Reset in the middle of MEMWR: memwrite drops at once.
        for (int k = 0; k < 3; k++) begin
            bool_drive(OP_SW, 6'h00, k);
            @(posedge clk); #1;
        end
        check("sw memwrite before reset", 32'(memwrite), 32'(1));
        #2 reset = 1'b1;
        #1 check("reset mid memwr", 32'(act), 32'(fetch_view()));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("reset after memwr %0d", i), 32'(act), 32'(fetch_view()));
        end
        reset = 1'b0;
        #1;
        e = exp_cycle(OP_SW, 6'h0, 0, zero);
        check("fetch after mid reset", 32'(act), 32'(e));

        // Random instruction stream.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: o = OP_LW;
                1: o = OP_SW;
                2: o = OP_RTYPE;
                3: o = OP_BEQ;
                4: o = OP_ADDI;
                5: o = OP_J;
                default: begin
                    o = 6'($urandom);
                    if (is_legal_op(o)) o = 6'b110000;
                end
            endcase
            case ($urandom_range(0, 5))
                0: f = FN_ADD;
                1: f = FN_SUB;
                2: f = FN_AND;
                3: f = FN_OR;
                4: f = FN_SLT;
                default: f = 6'($urandom);
            endcase
            run_model($sformatf("rand%0d op=%b fn=%b", i, o, f), o, f);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
